tiny_riscv_uart_tx_periph: RTL and testbench

//   Memory-mapped UART transmitter; bus responder on the processor memory interface (addr/write_data/write_mask/read_strobe).
//   CPU stores bytes into a FIFO; an 8N1 serialiser drives o_UART_TX.

---
 rtl/tiny_riscv_uart_tx_periph.sv | 170 +++++++++++++++++
 tb/tb_tiny_riscv_uart_tx_periph.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_riscv_uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes a FIFO, STATUS reports count/overflow/empty/full/busy.
// Reads return one cycle after the strobe; stores into a full FIFO are dropped and latch the sticky overflow flag.
module tiny_riscv_uart_tx_periph #(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [31:0] i_mem_addr,
    input  logic        i_read_strobe,
    output logic [31:0] o_mem_data,
    input  logic [31:0] i_mem_write_data,
    input  logic [3:0]  i_mem_write_mask,
    output logic        o_UART_TX,
    output logic        o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          sel, is_status, wr_txdata, full, empty;
    logic          push, pop, ovf_set, ovf_clr, overflow, busy_nxt;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel       = (i_mem_addr[31:3] == BASE_ADDR[31:3]);
    assign is_status = i_mem_addr[2];
    assign wr_txdata = sel & ~is_status & i_mem_write_mask[0];
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    // Full is judged on the pre-edge count, so a same-edge pop never rescues a store.
    assign push      = wr_txdata & ~full;
    assign ovf_set   = wr_txdata & full;
    assign ovf_clr   = sel & is_status & i_mem_write_mask[0] & i_mem_write_data[3];
    assign busy_nxt  = (state != IDLE) | ~empty;

    assign unused_bits = ^{i_mem_addr[1:0], i_mem_write_data[31:8], i_mem_write_mask[3:1]};

    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_mem_write_data[7:0];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_UART_TX <= 1'b1;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            o_UART_TX <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = 1'b1;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_mem[rd_ptr];
                    clk_cnt_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + BW'(1);
                end
            end
            DATA: begin
                tx_nxt = shift[bit_idx];
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + BW'(1);
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    clk_cnt_nxt = clk_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        status_word           = '0;
        status_word[8 +: CW]  = count;
        status_word[3:0]      = {overflow, empty, full, busy_nxt};
    end

    // Read data is forced to zero when unselected so it can be ORed onto the memory read bus.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_mem_data <= '0;
            overflow   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_busy <= busy_nxt;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            o_mem_data <= (sel && i_read_strobe && is_status) ? status_word : '0;
        end
    end

endmodule

// File: tb/tb_tiny_riscv_uart_tx_periph.sv
// Directed bench for the UART TX peripheral: a line monitor decodes frames and checks them against a byte scoreboard.
module tb_tiny_riscv_uart_tx_periph;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] STAT = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rstrobe;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        tx;
    logic        busy;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  exp_q[$];
    int          start_cyc[$];
    int          frames_seen = 0;
    bit          frame_abort = 1'b0;

    logic [7:0]  b2 = 8'hA5;
    logic        etx;
    int          n0;
    int          f0;
    bit          all_high;
    logic [7:0]  t3_bytes [5] = '{8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF};
    logic [7:0]  t6_bytes [6] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h99, 8'h66};

    tiny_riscv_uart_tx_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (BASE)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_mem_addr      (addr),
        .i_read_strobe   (rstrobe),
        .o_mem_data      (rdata),
        .i_mem_write_data(wdata),
        .i_mem_write_mask(wmask),
        .o_UART_TX       (tx),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        @(negedge clk);
        addr  = '0;
        wdata = '0;
        wmask = '0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] expv);
        addr    = a;
        rstrobe = 1'b1;
        @(negedge clk);
        addr    = '0;
        rstrobe = 1'b0;
        chk(tag, rdata, expv);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 600), 32'd1);
    endtask

    // Line monitor: samples mid-bit on falling clock edges and scores each completed frame.
    initial begin : monitor
        logic [7:0] b;
        logic       ok_start;
        logic       ok_stop;
        int         st;
        forever begin
            @(negedge clk);
            if (o_tx_low() && rst === 1'b0) begin
                st = cyc;
                @(negedge clk);
                ok_start = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ok_stop = (tx === 1'b1);
                if (!frame_abort) begin
                    frames_seen++;
                    start_cyc.push_back(st);
                    chk("frame_start_bit", 32'(ok_start), 32'd1);
                    chk("frame_stop_bit", 32'(ok_stop), 32'd1);
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("frame_data", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    function automatic bit o_tx_low();
        return (tx === 1'b0);
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed unfinished run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst     = 1'b1;
        addr    = '0;
        rstrobe = 1'b0;
        wdata   = '0;
        wmask   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state and idle STATUS
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        bus_read("t1_status", STAT, 32'h0000_0004);
        @(negedge clk);
        chk("t1_rdata_clears", rdata, 32'd0);

        // 2: single byte, exact line waveform and busy timing
        exp_q.push_back(b2);
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        chk("t2_busy_k0", 32'(busy), 32'd0);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k < 2) etx = 1'b1;
            else if (k < 6) etx = 1'b0;
            else if (k < 38) etx = b2[(k - 6) / 4];
            else etx = 1'b1;
            chk($sformatf("t2_tx_k%0d", k), 32'(tx), 32'(etx));
            chk($sformatf("t2_busy_k%0d", k), 32'(busy), 32'(k <= 41));
        end
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: five consecutive stores while idle; all accepted, frames separated by one idle clock
        n0 = start_cyc.size();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(t3_bytes[i]);
            bus_write(BASE, {24'h0, t3_bytes[i]}, 4'b0001);
        end
        drain("t3_drain");
        chk("t3_frames", 32'(start_cyc.size()), 32'(n0 + 5));
        if (start_cyc.size() >= n0 + 5) begin
            for (int i = 1; i < 5; i++) begin
                chk($sformatf("t3_gap%0d", i), 32'(start_cyc[n0 + i] - start_cyc[n0 + i - 1]), 32'(10 * CPB + 1));
            end
        end
        bus_read("t3_status", STAT, 32'h0000_0004);

        // 4: overflow while a frame is active, then W1C of the overflow flag
        exp_q.push_back(8'h11);
        bus_write(BASE, 32'h0000_0011, 4'b0001);
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h22);
        bus_write(BASE, 32'h0000_0022, 4'b0001);
        exp_q.push_back(8'h33);
        bus_write(BASE, 32'h0000_0033, 4'b0001);
        exp_q.push_back(8'h44);
        bus_write(BASE, 32'h0000_0044, 4'b0001);
        exp_q.push_back(8'h55);
        bus_write(BASE, 32'h0000_0055, 4'b0001);
        bus_write(BASE, 32'h0000_0066, 4'b0001);
        bus_read("t4_status_ovf", STAT, 32'h0000_040B);
        bus_write(STAT, 32'h0000_0007, 4'b0001);
        bus_read("t4_status_noclr", STAT, 32'h0000_040B);
        bus_write(STAT, 32'h0000_0008, 4'b0001);
        bus_read("t4_status_clr", STAT, 32'h0000_0403);
        drain("t4_drain");

        // 5: stores outside the window or on the wrong lane, and unselected reads
        bus_write(BASE + 32'h8, 32'h0000_0055, 4'b0001);
        bus_write(BASE, 32'h0000_0055, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_tx%0d", k), 32'(tx), 32'd1);
            chk($sformatf("t5_busy%0d", k), 32'(busy), 32'd0);
        end
        bus_read("t5_status", STAT, 32'h0000_0004);
        bus_read("t5_outside", BASE + 32'h10, 32'd0);
        bus_read("t5_status2", STAT, 32'h0000_0004);
        bus_read("t5_txdata", BASE, 32'd0);

        // 6: reset in the middle of a data bit that is low
        f0 = frames_seen;
        frame_abort = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_write(BASE, {24'h0, t6_bytes[i]}, 4'b0001);
        end
        bus_read("t6_status_pre", STAT, 32'h0000_040B);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_tx_after_rst", 32'(tx), 32'd1);
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        chk("t6_rdata_after_rst", rdata, 32'd0);
        bus_read("t6_status_post", STAT, 32'h0000_0004);
        all_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        chk("t6_line_idle", 32'(all_high), 32'd1);
        frame_abort = 1'b0;
        chk("t6_no_frames", 32'(frames_seen), 32'(f0));
        chk("t6_busy_idle", 32'(busy), 32'd0);
        chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
